// File: rtl/bin2bcd_display_feed.sv
// rtl/bin2bcd_display_feed.sv - sequential double-dabble binary to 4-digit BCD converter
module bin2bcd_display_feed #(
    parameter int          W_IN     = 14,
    parameter bit          AUTO     = 1'b0,
    parameter logic [15:0] OVF_CODE = 16'hEEEE
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [W_IN-1:0] bin_in,
    output logic            busy,
    output logic            done,
    output logic            overflow,
    output logic [15:0]     bcd_out
);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t          state;
    state_t          next_state;
    logic [W_IN-1:0] shift_reg;
    logic [15:0]     scratch;
    logic [15:0]     scratch_adj;
    logic [3:0]      cnt;
    logic            ovf_pend;
    logic            accept;

    // A request is taken only while idle; AUTO makes the block re-arm itself every period.
    always_comb begin
        accept = (state == IDLE) && (start || AUTO);
    end

    // Per-nibble add-3 with no inter-nibble carry; nibbles never exceed 9 before correction.
    always_comb begin
        scratch_adj = scratch;
        for (int i = 0; i < 4; i++) begin
            if (scratch[4*i +: 4] >= 4'd5) begin
                scratch_adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
            end
        end
    end

    // Next-state logic: SHIFT runs exactly W_IN edges, DONE is a single publish edge.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = SHIFT;
            SHIFT:   if (cnt == 4'd1) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Datapath and registered outputs; bcd_out/overflow move only on the DONE edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            shift_reg <= '0;
            scratch   <= '0;
            cnt       <= '0;
            ovf_pend  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            overflow  <= 1'b0;
            bcd_out   <= 16'h0000;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        shift_reg <= bin_in;
                        scratch   <= '0;
                        cnt       <= 4'(W_IN);
                        ovf_pend  <= ({{(32-W_IN){1'b0}}, bin_in} > 32'd9999);
                        busy      <= 1'b1;
                    end
                end
                SHIFT: begin
                    scratch   <= {scratch_adj[14:0], shift_reg[W_IN-1]};
                    shift_reg <= shift_reg << 1;
                    cnt       <= cnt - 4'd1;
                end
                DONE: begin
                    bcd_out  <= ovf_pend ? OVF_CODE : scratch;
                    overflow <= ovf_pend;
                    done     <= 1'b1;
                    busy     <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bin2bcd_display_feed.sv
// tb/tb_bin2bcd_display_feed.sv - vector-table bench for bin2bcd_display_feed
module tb_bin2bcd_display_feed;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [13:0] bin_in;
    logic        busy;
    logic        done;
    logic        overflow;
    logic [15:0] bcd_out;

    logic        reset2;
    logic        start2;
    logic [13:0] bin2;
    logic        busy2;
    logic        done2;
    logic        ovf2;
    logic [15:0] bcd2;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    bin2bcd_display_feed #(.W_IN(14), .AUTO(1'b0), .OVF_CODE(16'hEEEE)) dut (
        .clk(clk), .reset(reset), .start(start), .bin_in(bin_in),
        .busy(busy), .done(done), .overflow(overflow), .bcd_out(bcd_out)
    );

    bin2bcd_display_feed #(.W_IN(14), .AUTO(1'b1), .OVF_CODE(16'hEEEE)) dut_auto (
        .clk(clk), .reset(reset2), .start(start2), .bin_in(bin2),
        .busy(busy2), .done(done2), .overflow(ovf2), .bcd_out(bcd2)
    );

    typedef struct {
        logic [13:0] bin;
        logic [15:0] bcd;
        logic        ovf;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic is_bcd(input logic [15:0] v);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (v[4*i +: 4] > 4'd9) ok = 1'b0;
        end
        return ok;
    endfunction

    // Waits at negedges for done (bounded); k = negedges waited; flags output movement before done.
    task automatic wait_done(output int k, output logic moved);
        logic [15:0] hold_b;
        logic        hold_o;
        logic        seen;
        hold_b = bcd_out;
        hold_o = overflow;
        moved  = 1'b0;
        seen   = 1'b0;
        k      = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            k++;
            if (done) seen = 1'b1;
            else if (bcd_out !== hold_b || overflow !== hold_o) moved = 1'b1;
        end
        if (!seen) k = -1;
    endtask

    task automatic run_vec(input string nm, input logic [13:0] v, input logic [15:0] eb, input logic eo);
        int   k;
        logic moved;
        @(negedge clk);
        start  = 1'b1;
        bin_in = v;
        @(negedge clk);
        start  = 1'b0;
        bin_in = ~v;
        check({nm, " busy"}, 32'(busy), 32'd1);
        wait_done(k, moved);
        check({nm, " latency"}, 32'(k), 32'd15);
        check({nm, " held"}, 32'(moved), 32'd0);
        check({nm, " bcd"}, 32'(bcd_out), 32'(eb));
        check({nm, " ovf"}, 32'(overflow), 32'(eo));
        @(negedge clk);
        check({nm, " done width"}, 32'(done), 32'd0);
        check({nm, " idle busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int   k;
        int   last_t;
        int   last_v;
        int   pulses;
        logic moved;
        logic spurious;
        logic all_bcd;

        vecs[0] = '{14'd1234,  16'h1234, 1'b0};
        vecs[1] = '{14'd0,     16'h0000, 1'b0};
        vecs[2] = '{14'd9999,  16'h9999, 1'b0};
        vecs[3] = '{14'd10000, 16'hEEEE, 1'b1};
        vecs[4] = '{14'd9,     16'h0009, 1'b0};
        vecs[5] = '{14'd100,   16'h0100, 1'b0};
        vecs[6] = '{14'd8191,  16'h8191, 1'b0};
        vecs[7] = '{14'd16383, 16'hEEEE, 1'b1};

        reset  = 1'b1;
        start  = 1'b0;
        bin_in = '0;
        reset2 = 1'b1;
        start2 = 1'b0;
        bin2   = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset ovf", 32'(overflow), 32'd0);
        check("reset bcd", 32'(bcd_out), 32'd0);

        for (int i = 0; i < 8; i++) begin
            run_vec($sformatf("vec%0d", i), vecs[i].bin, vecs[i].bcd, vecs[i].ovf);
        end

        // Reset sampled on the 6th SHIFT edge of a 5678 conversion.
        @(negedge clk);
        start  = 1'b1;
        bin_in = 14'd5678;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midreset busy", 32'(busy), 32'd0);
        check("midreset bcd", 32'(bcd_out), 32'd0);
        check("midreset ovf", 32'(overflow), 32'd0);
        check("midreset done", 32'(done), 32'd0);
        reset    = 1'b0;
        spurious = 1'b0;
        repeat (25) begin
            @(negedge clk);
            if (done || busy) spurious = 1'b1;
        end
        check("midreset no done", 32'(spurious), 32'd0);
        run_vec("after reset", 14'd5678, 16'h5678, 1'b0);

        // start held through a conversion, bin_in changed mid-way.
        @(negedge clk);
        start  = 1'b1;
        bin_in = 14'd42;
        @(negedge clk);
        check("hold busy", 32'(busy), 32'd1);
        repeat (3) @(negedge clk);
        bin_in = 14'd7;
        wait_done(k, moved);
        check("hold latency", 32'(k + 3), 32'd15);
        check("hold first bcd", 32'(bcd_out), 32'h0042);
        @(negedge clk);
        start = 1'b0;
        check("hold rearm busy", 32'(busy), 32'd1);
        wait_done(k, moved);
        check("hold spacing", 32'(k + 1), 32'd16);
        check("hold second bcd", 32'(bcd_out), 32'h0007);

        // Back-to-back with start held high.
        @(negedge clk);
        start  = 1'b1;
        bin_in = 14'd300;
        @(negedge clk);
        bin_in = 14'd301;
        wait_done(k, moved);
        check("b2b first latency", 32'(k), 32'd15);
        check("b2b first bcd", 32'(bcd_out), 32'h0300);
        @(negedge clk);
        start = 1'b0;
        wait_done(k, moved);
        check("b2b spacing", 32'(k + 1), 32'd16);
        check("b2b second bcd", 32'(bcd_out), 32'h0301);

        // AUTO instance tracks a stepping input.
        @(negedge clk);
        reset2  = 1'b0;
        bin2    = 14'd0;
        last_t  = -1;
        last_v  = 0;
        pulses  = 0;
        all_bcd = 1'b1;
        for (int cyc = 0; cyc < 160; cyc++) begin
            @(negedge clk);
            if (cyc == 40) bin2 = 14'd1;
            if (cyc == 80) bin2 = 14'd2;
            if (!is_bcd(bcd2) || bcd2 > 16'h0002) all_bcd = 1'b0;
            if (done2) begin
                pulses++;
                if (last_t >= 0) check("auto spacing", 32'(cyc - last_t), 32'd16);
                check("auto monotonic", 32'(int'(bcd2) >= last_v), 32'd1);
                last_t = cyc;
                last_v = int'(bcd2);
            end
        end
        check("auto all bcd", 32'(all_bcd), 32'd1);
        check("auto pulse count", 32'(pulses >= 9), 32'd1);
        check("auto final bcd", 32'(bcd2), 32'h0002);
        check("auto ovf", 32'(ovf2), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
